res_arb: RTL and testbench

RES_ARB -- requirements
Module: res_arb

---
 rtl/res_arb_pkg.sv | 29 ++
 rtl/res_arb_if.sv | 40 ++++
 rtl/res_arb_pick.sv | 42 ++++
 rtl/res_arb.sv | 135 +++++++++++++
 tb/tb_res_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/res_arb_pkg.sv
// res_arb_pkg: sizes, FSM encoding and small helpers
// shared by the result-RAM arbiter files.
package res_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef logic [1:0] tag_t;

  function automatic logic [NUM_REQ-1:0] lowest(
    input logic [NUM_REQ-1:0] v
  );
    return v & (~v + NUM_REQ'(1));
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(
    input tag_t t
  );
    return NUM_REQ'(1) << t;
  endfunction

endpackage

// File: rtl/res_arb_if.sv
// res_arb_if: requester handshakes, shared response
// and result-RAM port of the arbiter.
interface res_arb_if;
  import res_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           res_rd;
  logic                           res_wr;
  logic [ADDR_W-1:0]              res_addr;
  logic [DATA_W-1:0]              res_do;
  logic [DATA_W-1:0]              res_di;
  logic                           busy;

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    input  res_di,
    output req_ready, rsp_valid,
    output rsp_data, busy,
    output res_rd, res_wr,
    output res_addr, res_do
  );

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    output res_di,
    input  req_ready, rsp_valid,
    input  rsp_data, busy,
    input  res_rd, res_wr,
    input  res_addr, res_do
  );

endinterface

// File: rtl/res_arb_pick.sv
// res_arb_pick: one-hot grant from the request bits.
// RES_ARB_RR_EN selects round-robin, else fixed 0>1>2.
module res_arb_pick
  import res_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  tag_t               i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef RES_ARB_RR_EN
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_sel;

  // rotate so the pointer slot is bit 0
  always_comb begin
    w_rot = i_valid;
    unique case (i_ptr)
      2'd1:    w_rot = {i_valid[0], i_valid[2:1]};
      2'd2:    w_rot = {i_valid[1:0], i_valid[2]};
      default: w_rot = i_valid;
    endcase
  end

  assign w_sel = lowest(w_rot);

  always_comb begin
    o_grant = w_sel;
    unique case (i_ptr)
      2'd1:    o_grant = {w_sel[1:0], w_sel[2]};
      2'd2:    o_grant = {w_sel[0], w_sel[2:1]};
      default: o_grant = w_sel;
    endcase
  end
`else
  logic w_unused_ptr;

  assign w_unused_ptr = ^i_ptr;
  assign o_grant      = lowest(i_valid);
`endif

endmodule

// File: rtl/res_arb.sv
// res_arb: three requesters share one result-RAM port.
// RES_ARB_RR_EN enables round-robin arbitration.
module res_arb
  import res_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  res_arb_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_init;
  logic               r_rd;
  logic               r_wr;
  logic               r_pend;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_do;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_valid;
  tag_t               r_tag;

  tag_t               w_ptr;
  tag_t               w_idx;
  logic               w_allow;
  logic               w_acc;
  logic               w_we;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;

  // slot after a read is lost: one read in flight
  assign w_allow = r_init & ~r_rd;

  res_arb_pick u_pick (
    .i_valid (bus.req_valid & {NUM_REQ{w_allow}}),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  assign w_acc = |w_grant;

  always_comb begin
    w_idx   = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (1'b1)
      w_grant[0]: begin
        w_idx   = 2'd0;
        w_we    = bus.req_we[0];
        w_addr  = bus.req_addr[0];
        w_wdata = bus.req_wdata[0];
      end
      w_grant[1]: begin
        w_idx   = 2'd1;
        w_we    = bus.req_we[1];
        w_addr  = bus.req_addr[1];
        w_wdata = bus.req_wdata[1];
      end
      w_grant[2]: begin
        w_idx   = 2'd2;
        w_we    = bus.req_we[2];
        w_addr  = bus.req_addr[2];
        w_wdata = bus.req_wdata[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = IDLE;
    unique case (r_state)
      IDLE: begin
        if (w_acc) w_state_nx = ISSUE;
      end
      ISSUE, RD_WAIT: begin
        if (w_acc) w_state_nx = w_we ? ISSUE : RD_WAIT;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_init      <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_pend      <= 1'b0;
      r_addr      <= '0;
      r_do        <= '0;
      r_tag       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_init  <= 1'b1;
      r_rd    <= w_acc & ~w_we;
      r_wr    <= w_acc & w_we;
      r_pend  <= r_rd;
      if (w_acc) r_addr <= w_addr;
      if (w_acc && w_we) r_do <= w_wdata;
      if (w_acc && !w_we) r_tag <= w_idx;
      r_rsp_valid <= r_pend ? onehot(r_tag) : '0;
      if (r_pend) r_rsp_data <= bus.res_di;
    end
  end

`ifdef RES_ARB_RR_EN
  tag_t r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.res_rd    = r_rd;
  assign bus.res_wr    = r_wr;
  assign bus.res_addr  = r_addr;
  assign bus.res_do    = r_do;
  assign bus.busy      = r_rd | r_wr | r_pend;

endmodule

// File: tb/tb_res_arb.sv
// tb_res_arb: random + directed traffic against a
// cycle-timeline model of the result-RAM arbiter.
module tb_res_arb;
  import res_arb_pkg::*;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } txn_t;
  typedef struct {int cyc; int idx;} acc_e;
  typedef struct {
    int cyc; logic wr; logic [13:0] a; logic [7:0] d;
  } str_e;
  typedef struct {int cyc; logic [2:0] v; logic [7:0] d;} rsp_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  res_arb_if bus();

  res_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gate = 100;

  txn_t rq[3][$];
  logic [2:0] acc = '0;
  logic [2:0] pres = '0;
  acc_e alog[$];
  str_e slog[$];
  rsp_e rlog[$];

  logic [7:0] ram [16384];
  logic [7:0] mmem [16384];

  // model state
  int         m_ptr;
  bit         m_first, m_rdblk, m_prev_rd;
  bit         f_rd[4], f_wr[4];
  logic [13:0] f_addr[4];
  logic [7:0] f_do[4], f_rdat[4];
  logic [2:0] f_rv[4];
  logic [13:0] m_addr;
  logic [7:0] m_do, m_rsp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int mpick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      int i = (p + k) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'(a >> 6);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_first = 1; m_rdblk = 0; m_prev_rd = 0;
    for (int k = 0; k < 4; k++) begin
      f_rd[k] = 0; f_wr[k] = 0; f_addr[k] = '0;
      f_do[k] = '0; f_rdat[k] = '0; f_rv[k] = '0;
    end
    m_addr = '0; m_do = '0; m_rsp = '0;
  endtask

  // RAM environment, monitor and model compare
  always @(negedge clk) begin : mon
    int g;
    int ai;
    logic [2:0] v;
    logic [2:0] er;
    cyc++;
    if (bus.res_wr) ram[bus.res_addr] = bus.res_do;
    if (bus.res_rd) bus.res_di = ram[bus.res_addr];
    if (!rst_n) begin
      bus.res_di = '0;
      acc = '0;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_rspv", 32'(bus.rsp_valid), 0);
      chk("rst_rspd", 32'(bus.rsp_data), 0);
      chk("rst_rd", 32'(bus.res_rd), 0);
      chk("rst_wr", 32'(bus.res_wr), 0);
      chk("rst_addr", 32'(bus.res_addr), 0);
      chk("rst_do", 32'(bus.res_do), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      model_reset();
    end else begin
      if (f_wr[0] || f_rd[0]) m_addr = f_addr[0];
      if (f_wr[0]) m_do = f_do[0];
      if (f_rv[0] != 0) m_rsp = f_rdat[0];
      v = (m_first || m_rdblk) ? 3'b000 : bus.req_valid;
      g = mpick(v, m_ptr);
      er = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("ready", 32'(bus.req_ready), 32'(er));
      chk("res_rd", 32'(bus.res_rd), 32'(f_rd[0]));
      chk("res_wr", 32'(bus.res_wr), 32'(f_wr[0]));
      chk("res_addr", 32'(bus.res_addr), 32'(m_addr));
      chk("res_do", 32'(bus.res_do), 32'(m_do));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(f_rv[0]));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp));
      chk("busy", 32'(bus.busy),
          32'(f_rd[0] | f_wr[0] | m_prev_rd));
      // observation logs for the directed scenarios
      acc = bus.req_valid & bus.req_ready;
      if (|bus.req_valid) begin
        ai = -1;
        for (int i = 0; i < 3; i++) if (acc[i]) ai = i;
        alog.push_back('{cyc, ai});
      end
      if (bus.res_rd || bus.res_wr)
        slog.push_back('{cyc, bus.res_wr, bus.res_addr, bus.res_do});
      if (|bus.rsp_valid)
        rlog.push_back('{cyc, bus.rsp_valid, bus.rsp_data});
      // advance the model one cycle
      m_prev_rd = f_rd[0];
      m_first = 0;
      m_rdblk = 0;
      for (int k = 0; k < 3; k++) begin
        f_rd[k] = f_rd[k+1]; f_wr[k] = f_wr[k+1];
        f_addr[k] = f_addr[k+1]; f_do[k] = f_do[k+1];
        f_rv[k] = f_rv[k+1]; f_rdat[k] = f_rdat[k+1];
      end
      f_rd[3] = 0; f_wr[3] = 0; f_rv[3] = '0;
      if (g >= 0) begin
        f_addr[0] = bus.req_addr[g];
        if (bus.req_we[g]) begin
          f_wr[0] = 1;
          f_do[0] = bus.req_wdata[g];
          mmem[bus.req_addr[g]] = bus.req_wdata[g];
        end else begin
          f_rd[0] = 1;
          f_rv[2] = 3'(1 << g);
          f_rdat[2] = mmem[bus.req_addr[g]];
          m_rdblk = 1;
        end
`ifdef RES_ARB_RR_EN
        m_ptr = (g + 1) % 3;
`endif
      end
    end
  end

  // requester agents: hold a request until accepted
  always @(posedge clk) begin : drv
    txn_t h;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i] && rq[i].size() > 0) h = rq[i].pop_front();
      if (acc[i] || !pres[i])
        pres[i] = (rq[i].size() > 0) &&
                  ($urandom_range(99) < gate);
      bus.req_valid[i] = pres[i];
      if (pres[i]) begin
        h = rq[i][0];
        bus.req_we[i] = h.we;
        bus.req_addr[i] = h.addr;
        bus.req_wdata[i] = h.data;
      end else begin
        bus.req_we[i] = 1'b0;
        bus.req_addr[i] = '0;
        bus.req_wdata[i] = '0;
      end
    end
  end

  task automatic clear_logs();
    alog.delete(); slog.delete(); rlog.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < max) begin
      @(negedge clk); #1;
      n++;
      if (rq[0].size() == 0 && rq[1].size() == 0 &&
          rq[2].size() == 0 && bus.req_valid == 0 &&
          !bus.busy && bus.rsp_valid == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      checks++; errors++;
      $display("FAIL %s timeout: got busy expected idle", nm);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int e27[6];
    int rel;
    for (int a = 0; a < 16384; a++) begin
      ram[a] = init_val(a);
      mmem[a] = init_val(a);
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single write from req1
    clear_logs();
    rq[1].push_back('{1'b1, 14'h0081, 8'h05});
    wait_idle("w25", 50);
    chk("w25_nacc", alog.size(), 1);
    chk("w25_nstr", slog.size(), 1);
    if (alog.size() == 1 && slog.size() == 1) begin
      chk("w25_idx", alog[0].idx, 1);
      chk("w25_wr", 32'(slog[0].wr), 1);
      chk("w25_addr", 32'(slog[0].a), 32'h0081);
      chk("w25_do", 32'(slog[0].d), 32'h05);
      chk("w25_lat", slog[0].cyc - alog[0].cyc, 1);
    end

    // single read from req2
    ram[14'h3FFF] = 8'h7F;
    mmem[14'h3FFF] = 8'h7F;
    clear_logs();
    rq[2].push_back('{1'b0, 14'h3FFF, 8'h00});
    wait_idle("r26", 50);
    chk("r26_nrsp", rlog.size(), 1);
    if (rlog.size() == 1 && alog.size() == 1) begin
      chk("r26_vec", 32'(rlog[0].v), 32'b100);
      chk("r26_data", 32'(rlog[0].d), 32'h7F);
      chk("r26_lat", rlog[0].cyc - alog[0].cyc, 3);
    end

    // contention: all three keep writing
`ifdef RES_ARB_RR_EN
    e27 = '{0, 1, 2, 0, 1, 2};
`else
    e27 = '{0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    clear_logs();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 3; i++)
        rq[i].push_back('{1'b1, 14'(16'h100 + 16 * i + k), 8'(k)});
    wait_idle("c27", 200);
    chk("c27_n", 32'(alog.size() >= 6), 1);
    for (int k = 0; k < 6 && k < alog.size(); k++)
      chk($sformatf("c27_g%0d", k), alog[k].idx, e27[k]);

    // read and write in the same cycle, pointer at 1
    do_reset();
    rq[0].push_back('{1'b1, 14'h0010, 8'h11});
    wait_idle("p28", 50);
    clear_logs();
    rq[1].push_back('{1'b0, 14'h0010, 8'h00});
    rq[0].push_back('{1'b1, 14'h0020, 8'h22});
    wait_idle("s28", 50);
`ifdef RES_ARB_RR_EN
    chk("s28_n", alog.size(), 3);
    if (alog.size() == 3) begin
      chk("s28_g0", alog[0].idx, 1);
      chk("s28_g1", alog[1].idx, -1);
      chk("s28_g2", alog[2].idx, 0);
    end
`else
    chk("s28_n", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("s28_g0", alog[0].idx, 0);
      chk("s28_g1", alog[1].idx, 1);
    end
`endif
    chk("s28_nrsp", rlog.size(), 1);
    if (rlog.size() == 1) begin
      chk("s28_vec", 32'(rlog[0].v), 32'b010);
      chk("s28_data", 32'(rlog[0].d), 32'h11);
    end

    // reset pulse right after a read is accepted
    clear_logs();
    rq[1].push_back('{1'b0, 14'h0033, 8'h00});
    for (int n = 0; n < 20 && alog.size() == 0; n++) begin
      @(negedge clk); #1;
    end
    chk("x29_acc", 32'(alog.size() > 0), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    rq[0].push_back('{1'b1, 14'h0044, 8'h44});
    @(posedge clk); #2;
    clear_logs();
    rel = cyc;
    rst_n = 1'b1;
    wait_idle("x29", 50);
    chk("x29_nrsp", rlog.size(), 0);
    chk("x29_nlog", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("x29_c0", alog[0].cyc - rel, 1);
      chk("x29_g0", alog[0].idx, -1);
      chk("x29_c1", alog[1].cyc - rel, 2);
      chk("x29_g1", alog[1].idx, 0);
    end

    // throughput: 128 back-to-back writes
    clear_logs();
    for (int k = 0; k < 128; k++)
      rq[0].push_back('{1'b1, 14'(k), 8'(k) ^ 8'hA5});
    wait_idle("t30", 400);
    chk("t30_n", slog.size(), 128);
    if (slog.size() == 128)
      for (int k = 0; k < 128; k++) begin
        chk("t30_wr", 32'(slog[k].wr), 1);
        chk("t30_addr", 32'(slog[k].a), k);
        chk("t30_cyc", slog[k].cyc - slog[0].cyc, k);
      end

    // random mixed traffic
    gate = 70;
    repeat (1500) begin
      @(negedge clk); #2;
      for (int i = 0; i < 3; i++)
        if (rq[i].size() < 4 && $urandom_range(99) < 40)
          rq[i].push_back('{1'($urandom_range(1)),
                            14'($urandom_range(15)),
                            8'($urandom_range(255))});
    end
    wait_idle("rand", 300);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
